truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
Sequential stimulus-and-capture stage placed directly upstream of a 3-input combinational function block (inputs a, b, c; output y).
- On a start request it drives all 8 input combinations in ascending order.
- It waits a programmable settle time per combination, samples y, and assembles the 8-bit truth table.
- It reports completion with a one-cycle done pulse.
- Used for on-chip self-check of small combinational blocks and as a reusable bench driver.

Parameters:
SETTLE_CYCLES, 1, cycles each combination is held before y is sampled; legal range 1..255.
EXPECTED, 8'h31, golden truth table, bit i = y for {a,b,c}=i; default is y=1 for abc=000,100,101. Used only with CHECK_EN.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  sweep request; sampled only in IDLE.
y  input  1  output of the function block under test.
a  output  1  function input a = idx[2].
b  output  1  function input b = idx[1].
c  output  1  function input c = idx[0].
busy  output  1  high from the cycle after start is accepted through the last SETTLE cycle.
done  output  1  one-cycle pulse when the sweep completes.
table_out  output  8  captured truth table; bit i = sampled y for idx=i.

Behaviour:
- Reset values (one clock with reset=1): state=IDLE, idx=0, cnt=0, a=b=c=0, busy=0, done=0, table_out=8'h00. Reset overrides every other input, including mid-sweep; the partial table is discarded.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - a,b,c=0, busy=0, done=0; table_out holds its last value.
  - If start=1: idx<=0, cnt<=0, table_out<=8'h00, go to SETTLE.
- SETTLE:
  - busy=1; {a,b,c}={idx} (registered, glitch-free).
  - If cnt != SETTLE_CYCLES-1: cnt<=cnt+1.
  - If cnt == SETTLE_CYCLES-1:
    - table_out[idx] <= y.
    - If idx==7: go to DONE.
    - Else: idx<=idx+1 and cnt<=0.
  - Each combination is driven for exactly SETTLE_CYCLES cycles. y is sampled at the end of the last cycle.
- DONE: exactly one cycle; done=1, busy=0, a=b=c=0, table_out stable; then IDLE.
- Latency: start accepted at edge T; first combination driven from T+1; done high in cycle T+1+8*SETTLE_CYCLES.
- start while in SETTLE or DONE is ignored; there is no queuing. A start held high re-triggers in the first IDLE cycle after DONE.
- idx is 3 bits and never wraps inside a sweep; the sweep ends at idx=7.
- cnt is 8 bits. SETTLE_CYCLES outside 1..255 triggers an elaboration error ($error in a generate check).
- table_out is stable and valid whenever busy=0 after at least one completed sweep.

Optional Feature:
Macro SWEEP_CHECK_EN.
- Defined:
  - Adds output port match (1 bit) and output port err_count (4 bits).
  - At the end of DONE: match<=(table_out==EXPECTED).
  - err_count<=popcount(table_out ^ EXPECTED), range 0..8.
  - Both reset to 0, clear at start acceptance, and hold until the next start.
- Not defined: the ports and logic are absent; EXPECTED is unused; all other behaviour is identical.

Test Plan:
1. Reset, SETTLE_CYCLES=1, y wired to a function with truth table 8'h31. Pulse start at cycle 0 -> abc walks 000..111 on cycles 1..8; done=1 at cycle 9; table_out=8'h31; busy high on cycles 1..8.
2. SETTLE_CYCLES=3, y=idx[0] via model -> each abc value held 3 cycles; done at cycle 25 after acceptance; table_out=8'hAA.
3. Reset asserted for one cycle at idx=4 mid-sweep -> next cycle state=IDLE, a=b=c=0, busy=0, table_out=8'h00, no done pulse.
4. start pulsed again at idx=2 while busy -> ignored; a single done pulse at the normal time; table unaffected.
5. start held high continuously -> back-to-back sweeps, one IDLE cycle between DONE and the next SETTLE, one done pulse per sweep.
6. SWEEP_CHECK_EN defined, y forced 0 -> table_out=8'h00, match=0, err_count=3. With the correct function: match=1, err_count=0.

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// Sweep bus: start/y in, abc stimulus plus busy/done/table out.
// Ports: start, y, a, b, c, busy, done, table_out (+match, err_count with SWEEP_CHECK_EN).
interface truth_table_sweeper_if;
  logic       start;
  logic       y;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
`ifdef SWEEP_CHECK_EN
  logic       match;
  logic [3:0] err_count;

  modport master (
    output start, y,
    input  a, b, c, busy, done, table_out,
    input  match, err_count
  );

  modport slave (
    input  start, y,
    output a, b, c, busy, done, table_out,
    output match, err_count
  );
`else
  modport master (
    output start, y,
    input  a, b, c, busy, done, table_out
  );

  modport slave (
    input  start, y,
    output a, b, c, busy, done, table_out
  );
`endif
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks abc through 000..111, holds each SETTLE_CYCLES, captures y into table_out.
// Ports: clk, reset (sync, high), bus (slave). Optional check via macro SWEEP_CHECK_EN.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  EXPECTED      = 8'h31
) (
  input  logic                  clk,
  input  logic                  reset,
  truth_table_sweeper_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end

  logic [1:0] state;
  logic [2:0] idx;
  logic [7:0] cnt;
  logic [2:0] abc;
  logic       busy_q;
  logic       done_q;
  logic [7:0] tbl;
  logic       last;

  assign last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      idx    <= 3'd0;
      cnt    <= 8'd0;
      abc    <= 3'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tbl    <= 8'h00;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_SETTLE;
            idx    <= 3'd0;
            cnt    <= 8'd0;
            abc    <= 3'd0;
            busy_q <= 1'b1;
            tbl    <= 8'h00;
          end
        end
        S_SETTLE: begin
          if (!last) begin
            cnt <= cnt + 8'd1;
          end else begin
            tbl[idx] <= bus.y;
            if (idx == 3'd7) begin
              state  <= S_DONE;
              abc    <= 3'd0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              idx <= idx + 3'd1;
              cnt <= 8'd0;
              abc <= idx + 3'd1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.a         = abc[2];
  assign bus.b         = abc[1];
  assign bus.c         = abc[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.table_out = tbl;

`ifdef SWEEP_CHECK_EN
  logic [7:0] diff;
  logic [3:0] ones;
  logic       match_q;
  logic [3:0] err_q;

  assign diff = tbl ^ EXPECTED;

  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + 4'(diff[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      match_q <= 1'b0;
      err_q   <= 4'd0;
    end else if (state == S_IDLE && bus.start) begin
      match_q <= 1'b0;
      err_q   <= 4'd0;
    end else if (state == S_DONE) begin
      match_q <= (diff == 8'h00);
      err_q   <= ones;
    end
  end

  assign bus.match     = match_q;
  assign bus.err_count = err_q;
`else
  logic unused_expected;
  assign unused_expected = ^EXPECTED;
`endif

endmodule
